// File: rtl/sweep_gen.sv
// sweep_gen: chirp/sweep controller for a sinusoid NCO.
//   Steps nco_ctrl between min_ctrl and max_ctrl in up, down or triangle mode.
//   Endpoints are clamped and never wrap. Optional sweep-count bursts and an
//   inter-sweep dwell are supported. Configuration is captured on an accepted start.
//
// State table:
//   IDLE  | waiting for start; nco_reset=1, nco_ctrl holds its last value
//   SWEEP | stepping nco_ctrl once every div_q+1 cycles; nco_reset=0
//   DWELL | pause of delay_q step periods between sweeps; nco_reset=1
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       run handshake; stop is synchronous and wins over everything
//   mode              00 up, 01 down, 10 triangle, 11 reserved (rejected)
//   min_ctrl/max_ctrl sweep endpoints
//   inc_rate          step size per step tick
//   div_rate          step period minus one, in cycles
//   delay             dwell between sweeps, in step periods
//   count             sweeps per run, 0 = continuous
//   nco_ctrl          NCO frequency word
//   nco_reset         NCO reset (high outside SWEEP)
//   busy              high while not IDLE
//   sweep_done        one-cycle pulse per completed sweep
//   cfg_err           one-cycle pulse on a rejected start
module sweep_gen #(
  parameter int W  = 32,
  parameter int RW = 32,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  min_ctrl,
  input  logic [W-1:0]  max_ctrl,
  input  logic [W-1:0]  inc_rate,
  input  logic [RW-1:0] div_rate,
  input  logic [DW-1:0] delay,
  input  logic [7:0]    count,
  output logic [W-1:0]  nco_ctrl,
  output logic          nco_reset,
  output logic          busy,
  output logic          sweep_done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, SWEEP, DWELL} state_t;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  state_t        state;
  logic [1:0]    mode_q;
  logic [W-1:0]  min_q;
  logic [W-1:0]  max_q;
  logic [W-1:0]  inc_q;
  logic [RW-1:0] div_q;
  logic [DW-1:0] delay_q;
  logic [7:0]    count_q;
  logic [RW-1:0] rate_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [7:0]    swp_cnt;
  logic          dir_up;

  logic          tick;
  logic          at_end;
  logic          last_sweep;
  logic          dwell_last;
  logic [W-1:0]  up_step;
  logic [W-1:0]  dn_step;
  logic [W-1:0]  start_val;
  logic          start_dir;

  // Clamping compares differences so the step can never overflow or underflow.
  always_comb begin
    tick       = (rate_cnt >= div_q);
    at_end     = dir_up ? (nco_ctrl == max_q) : (nco_ctrl == min_q);
    up_step    = ((max_q - nco_ctrl) <= inc_q) ? max_q : nco_ctrl + inc_q;
    dn_step    = ((nco_ctrl - min_q) <= inc_q) ? min_q : nco_ctrl - inc_q;
    start_val  = (mode_q == MODE_DOWN) ? max_q : min_q;
    start_dir  = (mode_q != MODE_DOWN);
    last_sweep = (count_q != 8'd0) && ((swp_cnt + 8'd1) == count_q);
    dwell_last = ((dwell_cnt + DW'(1)) == delay_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
      inc_q      <= '0;
      div_q      <= '0;
      delay_q    <= '0;
      count_q    <= '0;
      rate_cnt   <= '0;
      dwell_cnt  <= '0;
      swp_cnt    <= '0;
      dir_up     <= 1'b1;
      nco_ctrl   <= '0;
      nco_reset  <= 1'b1;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        busy      <= 1'b0;
        nco_reset <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (mode == MODE_RSVD || min_ctrl > max_ctrl) begin
                cfg_err <= 1'b1;
              end else begin
                mode_q    <= mode;
                min_q     <= min_ctrl;
                max_q     <= max_ctrl;
                inc_q     <= inc_rate;
                div_q     <= div_rate;
                delay_q   <= delay;
                count_q   <= count;
                nco_ctrl  <= (mode == MODE_DOWN) ? max_ctrl : min_ctrl;
                dir_up    <= (mode != MODE_DOWN);
                rate_cnt  <= '0;
                dwell_cnt <= '0;
                swp_cnt   <= '0;
                state     <= SWEEP;
                busy      <= 1'b1;
                nco_reset <= 1'b0;
              end
            end
          end

          SWEEP: begin
            if (!tick) begin
              rate_cnt <= rate_cnt + RW'(1);
            end else begin
              rate_cnt <= '0;
              if (!at_end) begin
                nco_ctrl <= dir_up ? up_step : dn_step;
              end else if (mode_q == MODE_TRI && dir_up) begin
                // Turn around at max: the peak value is shown once, not twice.
                dir_up   <= 1'b0;
                nco_ctrl <= dn_step;
              end else begin
                sweep_done <= 1'b1;
                swp_cnt    <= swp_cnt + 8'd1;
                if (last_sweep) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  nco_reset <= 1'b1;
                end else if (delay_q == '0) begin
                  nco_ctrl <= start_val;
                  dir_up   <= start_dir;
                end else begin
                  state     <= DWELL;
                  nco_reset <= 1'b1;
                  nco_ctrl  <= start_val;
                  dir_up    <= start_dir;
                  dwell_cnt <= '0;
                end
              end
            end
          end

          DWELL: begin
            // rate_cnt keeps counting step periods; dwell_cnt counts periods.
            if (!tick) begin
              rate_cnt <= rate_cnt + RW'(1);
            end else begin
              rate_cnt <= '0;
              if (dwell_last) begin
                dwell_cnt <= '0;
                state     <= SWEEP;
                nco_reset <= 1'b0;
              end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
              end
            end
          end

          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            nco_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
